game_turn_ctrl: RTL and testbench

Turn sequencer between the direction FSM and the board datapath.
- Converts each new direction press (FSM `movement` code) into one complete turn: shift board, spawn tile, evaluate win/lose.
- Each phase is a start/done handshake with the datapath.
- Drives the `flag` input back into the direction FSM when the game ends or a handshake times out.

---
 rtl/game_pkg.sv | 49 ++++
 rtl/lfsr8.sv | 22 ++
 rtl/game_turn_ctrl.sv | 168 ++++++++++++++++
 tb/tb_game_turn_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared encodings for the direction FSM and the turn sequencer:
// movement codes, shift directions, result codes and controller states.
package game_pkg;

    typedef enum logic [2:0] {
        MV_INICIO      = 3'd0,
        MV_IZQUIERDA   = 3'd1,
        MV_DERECHA     = 3'd2,
        MV_ARRIBA      = 3'd3,
        MV_ABAJO       = 3'd4,
        MV_PERDIO_GANO = 3'd5,
        MV_ESPERA      = 3'd6,
        MV_CONTROL     = 3'd7
    } movement_e;

    typedef enum logic [1:0] {
        DIR_LEFT  = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_UP    = 2'b10,
        DIR_DOWN  = 2'b11
    } dir_e;

    typedef enum logic [1:0] {
        RES_PLAYING = 2'b00,
        RES_WON     = 2'b01,
        RES_LOST    = 2'b10,
        RES_ERROR   = 2'b11
    } result_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SHIFT = 3'd1,
        ST_SPAWN = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } state_e;

    // Only the four arrow states of the direction FSM count as a move.
    function automatic logic is_dir_move(input logic [2:0] m);
        return (m >= 3'(MV_IZQUIERDA)) && (m <= 3'(MV_ABAJO));
    endfunction

    // Arrow codes 1..4 map onto shift directions 0..3 (code minus one).
    function automatic logic [1:0] move_to_dir(input logic [2:0] m);
        return m[1:0] - 2'd1;
    endfunction

endpackage

// File: rtl/lfsr8.sv
// Free-running 8-bit Fibonacci LFSR (taps 8,6,5,4) used to pick spawn cells.
module lfsr8 #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] q
);

    logic feedback;

    assign feedback = q[7] ^ q[5] ^ q[4] ^ q[3];

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= SEED;
        end else begin
            q <= {q[6:0], feedback};
        end
    end

endmodule

// File: rtl/game_turn_ctrl.sv
// Turn sequencer: turns each direction press into shift -> spawn -> check
// handshakes with the board datapath and reports game end or errors to the FSM.
module game_turn_ctrl
    import game_pkg::*;
#(
    parameter int         TIMEOUT = 64,
    parameter int         CNT_W   = 10,
    parameter logic [7:0] SEED    = 8'hA5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       movement,
    input  logic             shift_done,
    input  logic             shift_changed,
    input  logic             spawn_done,
    input  logic             check_done,
    input  logic             win,
    input  logic             no_moves,
    output logic             shift_start,
    output logic [1:0]       shift_dir,
    output logic             spawn_start,
    output logic [3:0]       spawn_pos,
    output logic             check_start,
    output logic             flag,
    output logic [1:0]       result,
    output logic             busy,
    output logic [CNT_W-1:0] move_count
);

    localparam int            TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);

    state_e           state, state_n;
    logic [TW-1:0]    tmr, tmr_n;
    logic [2:0]       prev_mv;
    logic             pend_valid, pend_valid_n;
    logic [1:0]       pend_dir, pend_dir_n;
    logic [7:0]       lfsr_q;

    logic             press;
    logic [1:0]       press_dir;
    logic             busy_st;
    logic             tmr_last;
    logic [1:0]       dir_n;
    logic [1:0]       result_n;
    logic [CNT_W-1:0] count_n;
    logic             shift_start_n, spawn_start_n, check_start_n;
    logic             spawn_entry;

    lfsr8 #(.SEED(SEED)) u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr_q)
    );

    always_comb begin
        press         = is_dir_move(movement) && (movement != prev_mv);
        press_dir     = move_to_dir(movement);
        busy_st       = (state == ST_SHIFT) || (state == ST_SPAWN) || (state == ST_CHECK);
        tmr_last      = (tmr == TMR_LAST);

        state_n       = state;
        dir_n         = shift_dir;
        result_n      = result;
        count_n       = move_count;
        pend_valid_n  = pend_valid;
        pend_dir_n    = pend_dir;

        // A press mid-turn is remembered (latest wins); in IDLE it is consumed
        // directly, in DONE/ERR it is dropped.
        if (busy_st && press) begin
            pend_valid_n = 1'b1;
            pend_dir_n   = press_dir;
        end

        case (state)
            ST_IDLE: begin
                if (pend_valid) begin
                    state_n      = ST_SHIFT;
                    dir_n        = pend_dir;
                    pend_valid_n = 1'b0;
                end else if (press) begin
                    state_n = ST_SHIFT;
                    dir_n   = press_dir;
                end
            end
            ST_SHIFT: begin
                // First cycle is the start pulse itself; a done there is stale.
                if ((tmr != '0) && shift_done) begin
                    state_n = shift_changed ? ST_SPAWN : ST_IDLE;
                end
            end
            ST_SPAWN: begin
                if (spawn_done) begin
                    state_n = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (check_done) begin
                    if (move_count != '1) begin
                        count_n = move_count + 1'b1;
                    end
                    if (win) begin
                        state_n  = ST_DONE;
                        result_n = RES_WON;
                    end else if (no_moves) begin
                        state_n  = ST_DONE;
                        result_n = RES_LOST;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
            end
            default: begin
                state_n = state;
            end
        endcase

        // A done in the final allowed cycle has already moved state_n on.
        if (busy_st && (state_n == state) && tmr_last) begin
            state_n  = ST_ERR;
            result_n = RES_ERROR;
        end

        tmr_n         = (busy_st && (state_n == state)) ? tmr + 1'b1 : '0;
        shift_start_n = (state == ST_IDLE)  && (state_n == ST_SHIFT);
        spawn_start_n = (state == ST_SHIFT) && (state_n == ST_SPAWN);
        check_start_n = (state == ST_SPAWN) && (state_n == ST_CHECK);
        spawn_entry   = spawn_start_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            tmr         <= '0;
            prev_mv     <= '0;
            pend_valid  <= 1'b0;
            pend_dir    <= '0;
            shift_start <= 1'b0;
            shift_dir   <= '0;
            spawn_start <= 1'b0;
            spawn_pos   <= '0;
            check_start <= 1'b0;
            flag        <= 1'b0;
            result      <= '0;
            busy        <= 1'b0;
            move_count  <= '0;
        end else begin
            state       <= state_n;
            tmr         <= tmr_n;
            prev_mv     <= movement;
            pend_valid  <= pend_valid_n;
            pend_dir    <= pend_dir_n;
            shift_start <= shift_start_n;
            shift_dir   <= dir_n;
            spawn_start <= spawn_start_n;
            check_start <= check_start_n;
            flag        <= (state_n == ST_DONE) || (state_n == ST_ERR);
            result      <= result_n;
            busy        <= (state_n == ST_SHIFT) || (state_n == ST_SPAWN) || (state_n == ST_CHECK);
            move_count  <= count_n;
            if (spawn_entry) begin
                spawn_pos <= lfsr_q[3:0];
            end
        end
    end

endmodule

// File: tb/tb_game_turn_ctrl.sv
// Bench for game_turn_ctrl: directed turns plus randomized traffic, all checked
// every cycle against a phase-level reference model of the turn rules.
module tb_game_turn_ctrl;

    localparam int         TIMEOUT = 8;
    localparam int         CNT_W   = 3;
    localparam logic [7:0] SEED    = 8'hA5;
    localparam int         MAXC    = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [2:0]       movement = 3'd0;
    logic             shift_done = 1'b0, shift_changed = 1'b0;
    logic             spawn_done = 1'b0, check_done = 1'b0;
    logic             win = 1'b0, no_moves = 1'b0;
    logic             shift_start, spawn_start, check_start, flag, busy;
    logic [1:0]       shift_dir, result;
    logic [3:0]       spawn_pos;
    logic [CNT_W-1:0] move_count;

    int checks = 0;
    int failures = 0;

    game_turn_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W), .SEED(SEED)) dut (
        .clk           (clk),
        .rst           (rst),
        .movement      (movement),
        .shift_done    (shift_done),
        .shift_changed (shift_changed),
        .spawn_done    (spawn_done),
        .check_done    (check_done),
        .win           (win),
        .no_moves      (no_moves),
        .shift_start   (shift_start),
        .shift_dir     (shift_dir),
        .spawn_start   (spawn_start),
        .spawn_pos     (spawn_pos),
        .check_start   (check_start),
        .flag          (flag),
        .result        (result),
        .busy          (busy),
        .move_count    (move_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 waiting, 1 shifting, 2 spawning, 3 checking,
    // 4 game over, 5 error. age counts cycles spent in the current phase.
    int         m_ph = 0, m_age = 0, m_nx;
    logic [7:0] m_lfsr = SEED;
    logic [2:0] m_prev = 3'd0;
    bit         m_pv = 1'b0, m_press;
    logic [1:0] m_pd = 2'd0;
    logic       e_ss = 0, e_sps = 0, e_cs = 0, e_flag = 0, e_busy = 0;
    logic [1:0] e_dir = 0, e_res = 0;
    logic [3:0] e_pos = 0;
    int         e_cnt = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_ph = 0; m_age = 0; m_lfsr = SEED; m_prev = 3'd0; m_pv = 1'b0; m_pd = 2'd0;
            e_ss = 0; e_sps = 0; e_cs = 0; e_flag = 0; e_busy = 0;
            e_dir = 0; e_res = 0; e_pos = 0; e_cnt = 0;
        end else begin
            m_press = (movement >= 3'd1) && (movement <= 3'd4) && (movement != m_prev);
            m_nx = m_ph;
            e_ss = 0; e_sps = 0; e_cs = 0;
            if (m_ph == 0) begin
                if (m_pv) begin
                    m_nx = 1; e_dir = m_pd; m_pv = 1'b0;
                end else if (m_press) begin
                    m_nx = 1; e_dir = 2'(movement - 3'd1);
                end
            end else if (m_ph >= 1 && m_ph <= 3) begin
                if (m_ph == 1 && m_age > 0 && shift_done) m_nx = shift_changed ? 2 : 0;
                if (m_ph == 2 && spawn_done) m_nx = 3;
                if (m_ph == 3 && check_done) begin
                    if (e_cnt < MAXC) e_cnt++;
                    if (win) begin m_nx = 4; e_res = 2'b01; end
                    else if (no_moves) begin m_nx = 4; e_res = 2'b10; end
                    else m_nx = 0;
                end
                if (m_nx == m_ph && m_age == TIMEOUT - 1) begin m_nx = 5; e_res = 2'b11; end
                if (m_press) begin m_pv = 1'b1; m_pd = 2'(movement - 3'd1); end
            end
            if (m_ph == 0 && m_nx == 1) e_ss = 1;
            if (m_ph == 1 && m_nx == 2) begin e_sps = 1; e_pos = m_lfsr[3:0]; end
            if (m_ph == 2 && m_nx == 3) e_cs = 1;
            m_age  = (m_nx == m_ph) ? m_age + 1 : 0;
            e_flag = (m_nx >= 4);
            e_busy = (m_nx >= 1 && m_nx <= 3);
            m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
            m_prev = movement;
            m_ph   = m_nx;
        end
    end

    // Per-cycle compare plus event bookkeeping for the directed checks.
    bit   chk_en = 0;
    int   cyc = 0, n_ss = 0, n_sps = 0, n_cs = 0, t_sps = 0, t_flag = 0;
    logic [1:0] last_dir = 0;
    logic flag_d = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("shift_start", shift_start, e_ss);
            chk("spawn_start", spawn_start, e_sps);
            chk("check_start", check_start, e_cs);
            chk("shift_dir", shift_dir, e_dir);
            chk("spawn_pos", spawn_pos, e_pos);
            chk("flag", flag, e_flag);
            chk("result", result, e_res);
            chk("busy", busy, e_busy);
            chk("move_count", move_count, e_cnt);
            if (shift_start) begin n_ss++; last_dir = shift_dir; end
            if (spawn_start) begin n_sps++; t_sps = cyc; end
            if (check_start) n_cs++;
            if (flag && !flag_d) t_flag = cyc;
            flag_d = flag;
        end
    end

    // Datapath stand-in. mode 1: answer each start after a set delay;
    // mode 2: random done/flag noise every cycle.
    int mode = 0, d_sh = 1, d_sp = 1, d_ck = 1, p_done = 35;
    int cd_sh = 0, cd_sp = 0, cd_ck = 0;
    bit r_chg = 1, r_win = 0, r_nm = 0;

    always @(negedge clk) begin
        shift_done = 0; shift_changed = 0; spawn_done = 0;
        check_done = 0; win = 0; no_moves = 0;
        if (rst) begin
            cd_sh = 0; cd_sp = 0; cd_ck = 0;
        end else if (mode == 1) begin
            if (cd_sh > 0) begin cd_sh--; if (cd_sh == 0) begin shift_done = 1; shift_changed = r_chg; end end
            if (cd_sp > 0) begin cd_sp--; if (cd_sp == 0) spawn_done = 1; end
            if (cd_ck > 0) begin cd_ck--; if (cd_ck == 0) begin check_done = 1; win = r_win; no_moves = r_nm; end end
            if (shift_start) begin
                if (d_sh == 0) begin shift_done = 1; shift_changed = r_chg; end else cd_sh = d_sh;
            end
            if (spawn_start) begin
                if (d_sp == 0) spawn_done = 1; else cd_sp = d_sp;
            end
            if (check_start) begin
                if (d_ck == 0) begin check_done = 1; win = r_win; no_moves = r_nm; end else cd_ck = d_ck;
            end
        end else if (mode == 2) begin
            shift_done    = ($urandom_range(99) < p_done);
            shift_changed = 1'($urandom_range(1));
            spawn_done    = ($urandom_range(99) < p_done);
            check_done    = ($urandom_range(99) < p_done);
            win           = ($urandom_range(9) == 0);
            no_moves      = ($urandom_range(9) == 0);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #7;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
    endtask

    task automatic clr();
        n_ss = 0; n_sps = 0; n_cs = 0;
    endtask

    int k;

    initial begin
        mode = 1;
        tick(1);
        chk_en = 1;
        tick(1);
        chk("rst_flag", flag, 0);
        chk("rst_result", result, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", move_count, 0);
        chk("rst_shift_start", shift_start, 0);
        rst = 1'b0;

        // Left turn, button held.
        d_sh = 3; d_sp = 1; d_ck = 1; r_chg = 1;
        movement = 3'd7; tick(1);
        clr();
        movement = 3'd1; tick(5);
        movement = 3'd7; tick(10);
        chk("t1_shift_starts", n_ss, 1);
        chk("t1_dir", last_dir, 2'b00);
        chk("t1_spawn_starts", n_sps, 1);
        chk("t1_check_starts", n_cs, 1);
        chk("t1_count", move_count, 1);
        chk("t1_idle", busy, 0);

        // Shift that changes nothing.
        d_sh = 2; r_chg = 0;
        movement = 3'd0; tick(1);
        clr();
        movement = 3'd4; tick(10);
        chk("t2_shift_starts", n_ss, 1);
        chk("t2_dir", last_dir, 2'b11);
        chk("t2_no_spawn", n_sps, 0);
        chk("t2_count", move_count, 1);
        chk("t2_idle", busy, 0);

        // Two presses during SHIFT; the later one is the queued turn.
        d_sh = 6; r_chg = 1;
        movement = 3'd7; tick(1);
        clr();
        movement = 3'd1; tick(1);
        movement = 3'd7; tick(1);
        movement = 3'd2; tick(1);
        movement = 3'd7; tick(1);
        movement = 3'd3; tick(1);
        movement = 3'd7; tick(30);
        chk("t3_shift_starts", n_ss, 2);
        chk("t3_pending_dir", last_dir, 2'b10);
        chk("t3_check_starts", n_cs, 2);
        chk("t3_count", move_count, 3);

        // Counter saturation.
        d_sh = 1;
        for (int i = 0; i < 6; i++) begin
            movement = (i % 2 == 1) ? 3'd2 : 3'd1;
            tick(10);
        end
        chk("sat_count", move_count, MAXC);

        // Win beats no_moves; later presses ignored.
        r_win = 1; r_nm = 1;
        movement = 3'd4; tick(12);
        chk("t4_win_result", result, 2'b01);
        chk("t4_win_flag", flag, 1);
        clr();
        movement = 3'd1; tick(1);
        movement = 3'd2; tick(5);
        chk("t4_ignored", n_ss, 0);
        chk("t4_held_result", result, 2'b01);
        do_reset();
        chk("t4_rst_result", result, 0);
        r_win = 0; r_nm = 1;
        tick(12);
        chk("t4_lose_result", result, 2'b10);
        chk("t4_lose_flag", flag, 1);
        chk("t4_lose_count", move_count, 1);

        // Spawn never answered -> error.
        r_nm = 0; d_sh = 1; d_sp = 100;
        do_reset();
        movement = 3'd3;
        k = 0;
        while (!flag && k < 40) begin tick(1); k++; end
        if (k >= 40) chk("t5_wait_flag", 0, 1);
        chk("t5_err_latency", t_flag - t_sps, 8);
        chk("t5_err_result", result, 2'b11);
        chk("t5_err_flag", flag, 1);

        // Spawn answered in the last allowed cycle.
        d_sp = 7;
        do_reset();
        clr();
        movement = 3'd1; tick(25);
        chk("t5_late_check", n_cs, 1);
        chk("t5_late_flag", flag, 0);
        chk("t5_late_result", result, 0);
        chk("t5_late_count", move_count, 1);

        // Reset in the middle of CHECK.
        d_sp = 1; d_ck = 5;
        do_reset();
        clr();
        movement = 3'd2;
        k = 0;
        while (n_cs == 0 && k < 30) begin tick(1); k++; end
        if (k >= 30) chk("t6_wait_check", 0, 1);
        tick(2);
        movement = 3'd7;
        do_reset();
        chk("t6_shift_start", shift_start, 0);
        chk("t6_spawn_start", spawn_start, 0);
        chk("t6_check_start", check_start, 0);
        chk("t6_flag", flag, 0);
        chk("t6_busy", busy, 0);
        chk("t6_result", result, 0);
        chk("t6_count", move_count, 0);
        chk("t6_dir", shift_dir, 0);
        d_sh = 1; d_ck = 1;
        clr();
        movement = 3'd1;
        k = 0;
        while (n_sps == 0 && k < 20) begin tick(1); k++; end
        if (k >= 20) chk("t6_wait_spawn", 0, 1);
        chk("t6_fresh_turn", n_ss, 1);
        chk("t6_lfsr_pos", spawn_pos, 4'h5);
        tick(10);

        // Random traffic against the model.
        mode = 2;
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(99) < 2);
            if ($urandom_range(99) < 25) movement = 3'($urandom_range(7));
            tick(1);
        end
        rst = 1'b0;
        mode = 0;
        tick(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
